sram_bus_arbiter: RTL and testbench
===================================

Name: sram_bus_arbiter

Overview:
- Shares one class-SRAM memory port between the IF-stage instruction request and the EX/MEM data request.
- Grant is locked per transaction until address handshake; source tags for in-flight transactions are tracked in a FIFO so in-order responses route back to the right requester.
- Sits between the pipeline's fetch/data request logic and the single memory port (later the AXI bridge).

Parameters:
- OUTSTANDING, 2, max accepted-but-unanswered transactions (tag FIFO depth, ≥1).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst_req  in  1  instruction read request
- inst_size  in  2  access size (0=byte,1=half,2=word)
- inst_addr  in  32  instruction address
- inst_addr_ok  out  1  instruction request accepted this cycle
- inst_data_ok  out  1  instruction read data valid this cycle
- inst_rdata  out  32  instruction read data
- data_req  in  1  data request
- data_wr  in  1  1=write, 0=read
- data_size  in  2  access size
- data_addr  in  32  data address
- data_wstrb  in  4  byte write strobes
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response (read data or write done) this cycle
- data_rdata  out  32  data read data
- mem_req  out  1  request to shared port
- mem_wr  out  1  write flag
- mem_size  out  2  size
- mem_addr  out  32  address
- mem_wstrb  out  4  strobes (0 for instruction)
- mem_wdata  out  32  write data (0 for instruction)
- mem_addr_ok  in  1  port accepted request
- mem_data_ok  in  1  port response valid (responses strictly in request order)
- mem_rdata  in  32  port read data

Behaviour:
- Grant FSM: states IDLE, LOCK_I, LOCK_D; reset to IDLE.
- IDLE:
  - If FIFO not full and data_req: select data; if mem_addr_ok then stay in IDLE, else go to LOCK_D.
  - Else if FIFO not full and inst_req: same, selecting inst, else-branch to LOCK_I.
  - Data has fixed priority over inst.
- LOCK_x: selection held on master x regardless of the other master's req. On mem_addr_ok return to IDLE. If x drops req (protocol violation), return to IDLE with no push.
- mem_req = selected master's req, gated by ~fifo_full. All mem_* payload is a combinational mux of the selected master.
- Payload is not registered: zero-cycle req→mem_req path. x_addr_ok = mem_addr_ok & mem_req & (sel==x); only one is ever high.
- Tag FIFO, 1-bit tag (0=inst, 1=data), depth OUTSTANDING, pointers wrap modulo OUTSTANDING, count 0..OUTSTANDING.
  - Push on mem_req & mem_addr_ok; pop on mem_data_ok & ~empty.
  - Simultaneous push+pop: count unchanged, both pointers advance.
  - Full (count==OUTSTANDING): mem_req=0, FSM held (LOCK state is kept).
- Routing:
  - inst_data_ok = mem_data_ok & ~empty & head==0.
  - data_data_ok = mem_data_ok & ~empty & head==1.
  - inst_rdata = data_rdata = mem_rdata.
- mem_data_ok while FIFO empty: ignored, no x_data_ok, count stays 0.
- Reset values: FSM IDLE, count 0, pointers 0. With inputs low, all outputs are 0.
- Reset mid-transaction drops all tags; late mem_data_ok is then ignored per the empty rule.

Optional Feature:
- ARB_RR_EN defined:
  - IDLE priority is round-robin. A last_grant register (reset = inst) updates on each push.
  - When both request, the master not last granted wins.
- ARB_RR_EN undefined: fixed data-over-inst priority, no last_grant register.

Test Plan:
- Single read: inst_req=1, addr=0x1C000000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with rdata=0x02800C0C → inst_addr_ok pulse cycle 0, inst_data_ok + rdata cycle 2, data_data_ok stays 0.
- Contention: inst_req and data_req both 1 (data wr, addr 0x1000, wstrb 0xF, wdata 0xDEADBEEF) → data granted first with mem_wr=1, inst granted on the next accept; responses route data then inst. With ARB_RR_EN after a data grant → inst first.
- Lock: inst_req alone, mem_addr_ok held 0 for 3 cycles, data_req rises at cycle 1 → mem_addr stays inst_addr until accept; data accepted afterwards.
- Full: OUTSTANDING=2, accept two inst reads without responses → mem_req=0 while data_req=1. One mem_data_ok → mem_req reasserts next cycle.
- Push+pop same cycle at count=1 → count stays 1, head advances, correct x_data_ok.
- Spurious mem_data_ok after reset with empty FIFO → no data_ok outputs, count 0.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// Shares one class-SRAM port between instruction fetch and data access, with a tag FIFO
// routing in-order responses back. Define ARB_RR_EN for round-robin instead of data-first.
module sram_bus_arbiter #(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PtrW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CntW = $clog2(OUTSTANDING + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLockI = 2'd1;
    localparam logic [1:0] StLockD = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [OUTSTANDING-1:0] tag_q, tag_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   sel_inst, sel_data;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop, head;
    logic                   prefer_data;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef ARB_RR_EN
    // 1 = data was granted last; reset value favours data on the first tie.
    logic last_grant_q, last_grant_d;

    assign prefer_data  = ~last_grant_q;
    assign last_grant_d = push ? sel_data : last_grant_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign prefer_data = 1'b1;
`endif

    assign fifo_full  = (cnt_q == CntW'(OUTSTANDING));
    assign fifo_empty = (cnt_q == '0);

    always_comb begin
        sel_inst = 1'b0;
        sel_data = 1'b0;
        unique case (state_q)
            StLockI: sel_inst = 1'b1;
            StLockD: sel_data = 1'b1;
            default: begin
                if (!fifo_full) begin
                    if (data_req && (prefer_data || !inst_req)) begin
                        sel_data = 1'b1;
                    end else if (inst_req) begin
                        sel_inst = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        mem_req   = ((sel_inst & inst_req) | (sel_data & data_req)) & ~fifo_full;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        if (sel_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
        end else if (sel_inst) begin
            mem_size  = inst_size;
            mem_addr  = inst_addr;
        end
    end

    assign push = mem_req & mem_addr_ok;
    assign pop  = mem_data_ok & ~fifo_empty;
    assign head = tag_q[rd_ptr_q];

    assign inst_addr_ok = push & sel_inst;
    assign data_addr_ok = push & sel_data;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (sel_data && !mem_addr_ok) begin
                    state_d = StLockD;
                end else if (sel_inst && !mem_addr_ok) begin
                    state_d = StLockI;
                end
            end
            // A master dropping its request while locked releases the grant without a push.
            StLockI: begin
                if (!inst_req || (!fifo_full && mem_addr_ok)) begin
                    state_d = StIdle;
                end
            end
            StLockD: begin
                if (!data_req || (!fifo_full && mem_addr_ok)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            tag_d[wr_ptr_q] = sel_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios then random traffic,
// checked every cycle against a queue-based model of the arbitration rules.
module tb_sram_bus_arbiter;

    localparam int unsigned Out = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req, data_req, data_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
    logic [3:0]  data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OUTSTANDING(Out)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: in-flight sources in order (1 = data), who holds the grant (0 none,1 inst,2 data).
    bit tags[$];
    int lock_m = 0;
    bit last_data = 1'b0;

    int          e_owner;
    bit          e_full, e_pop, e_head, e_mem_req, e_mem_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic predict();
        e_full = (tags.size() == Out);
        if (lock_m != 0) e_owner = lock_m;
        else if (e_full) e_owner = 0;
        else if (data_req && inst_req) begin
`ifdef ARB_RR_EN
            e_owner = last_data ? 1 : 2;
`else
            e_owner = 2;
`endif
        end
        else if (data_req) e_owner = 2;
        else if (inst_req) e_owner = 1;
        else e_owner = 0;
        e_mem_req = !e_full && ((e_owner == 1 && inst_req) || (e_owner == 2 && data_req));
        e_mem_wr = 1'b0; e_size = 2'd0; e_addr = 32'd0; e_wstrb = 4'd0; e_wdata = 32'd0;
        if (e_owner == 2) begin
            e_mem_wr = data_wr; e_size = data_size; e_addr = data_addr;
            e_wstrb = data_wstrb; e_wdata = data_wdata;
        end else if (e_owner == 1) begin
            e_size = inst_size; e_addr = inst_addr;
        end
        e_pop  = mem_data_ok && (tags.size() != 0);
        e_head = (tags.size() != 0) ? tags[0] : 1'b0;
    endtask

    task automatic check_all();
        predict();
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_mem_req});
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_mem_wr});
        chk("mem_size", {30'd0, mem_size}, {30'd0, e_size});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_wstrb});
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("inst_addr_ok", {31'd0, inst_addr_ok},
            {31'd0, e_mem_req && mem_addr_ok && e_owner == 1});
        chk("data_addr_ok", {31'd0, data_addr_ok},
            {31'd0, e_mem_req && mem_addr_ok && e_owner == 2});
        chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, e_pop && !e_head});
        chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, e_pop && e_head});
        chk("inst_rdata", inst_rdata, mem_rdata);
        chk("data_rdata", data_rdata, mem_rdata);
    endtask

    task automatic model_update();
        predict();
        if (e_pop) void'(tags.pop_front());
        if (e_mem_req && mem_addr_ok) begin
            tags.push_back(e_owner == 2);
            last_data = (e_owner == 2);
        end
        if (lock_m == 0) begin
            if (e_mem_req && !mem_addr_ok) lock_m = e_owner;
        end else if ((lock_m == 1 && !inst_req) || (lock_m == 2 && !data_req)) begin
            lock_m = 0;
        end else if (!e_full && mem_addr_ok) begin
            lock_m = 0;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_size = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk);
        tags.delete(); lock_m = 0; last_data = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        do_reset();
        #1;
        chk("reset_mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        cyc();

        // Single instruction read, response two cycles later.
        inst_req = 1; inst_size = 2; inst_addr = 32'h1C00_0000; mem_addr_ok = 1;
        #1 chk("single_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        cyc();
        idle_inputs(); cyc();
        mem_data_ok = 1; mem_rdata = 32'h0280_0C0C;
        #1 chk("single_data_ok", {31'd0, inst_data_ok}, 32'd1);
        chk("single_rdata", inst_rdata, 32'h0280_0C0C);
        chk("single_no_data_ok", {31'd0, data_data_ok}, 32'd0);
        cyc();

        // Contention: data write wins first, instruction follows.
        idle_inputs();
        inst_req = 1; inst_size = 2; inst_addr = 32'h1C00_0004;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h1000;
        data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF; mem_addr_ok = 1;
        #1 chk("contend_first_wr", {31'd0, mem_wr}, 32'd1);
        cyc();
        data_req = 0;
        #1 chk("contend_second_inst", {31'd0, inst_addr_ok}, 32'd1);
        cyc();
        idle_inputs(); mem_data_ok = 1; mem_rdata = 32'h1111_2222;
        #1 chk("contend_resp_data", {31'd0, data_data_ok}, 32'd1);
        cyc();
        #1 chk("contend_resp_inst", {31'd0, inst_data_ok}, 32'd1);
        cyc();

        // Lock: inst held for three cycles while data arrives.
        idle_inputs(); inst_req = 1; inst_size = 2; inst_addr = 32'h1C00_0040;
        cyc();
        data_req = 1; data_addr = 32'h2000; data_size = 2;
        for (int i = 0; i < 2; i++) begin
            #1 chk("lock_addr", mem_addr, 32'h1C00_0040);
            cyc();
        end
        mem_addr_ok = 1;
        #1 chk("lock_accept", {31'd0, inst_addr_ok}, 32'd1);
        cyc();
        inst_req = 0;
        #1 chk("lock_then_data", {31'd0, data_addr_ok}, 32'd1);
        cyc();
        idle_inputs(); mem_data_ok = 1;
        cyc(); cyc();

        // Full: two reads outstanding block the data request until a response.
        idle_inputs(); inst_req = 1; inst_size = 2; inst_addr = 32'h1C00_0080; mem_addr_ok = 1;
        cyc(); cyc();
        inst_req = 0; data_req = 1; data_addr = 32'h3000;
        #1 chk("full_blocks", {31'd0, mem_req}, 32'd0);
        cyc();
        mem_data_ok = 1; mem_addr_ok = 0;
        cyc();
        mem_data_ok = 0;
        #1 chk("full_reassert", {31'd0, mem_req}, 32'd1);
        cyc();
        // Push and pop together at count 1.
        mem_addr_ok = 1; mem_data_ok = 1;
        #1 chk("pp_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        cyc();
        data_req = 0; mem_addr_ok = 0;
        #1 chk("pp_head_advanced", {31'd0, data_data_ok}, 32'd1);
        cyc();
        #1 chk("pp_drained", {31'd0, data_data_ok | inst_data_ok}, 32'd0);
        cyc();

        // Reset mid-transaction, then a stray response must be ignored.
        idle_inputs(); inst_req = 1; mem_addr_ok = 1; inst_addr = 32'h1C00_0100;
        cyc();
        idle_inputs();
        do_reset();
        mem_data_ok = 1;
        #1 chk("spurious_inst", {31'd0, inst_data_ok}, 32'd0);
        chk("spurious_data", {31'd0, data_data_ok}, 32'd0);
        cyc();

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            inst_req    = ($urandom_range(0, 99) < 55);
            data_req    = ($urandom_range(0, 99) < 45);
            inst_size   = 2'($urandom_range(0, 2));
            inst_addr   = $urandom;
            data_wr     = 1'($urandom);
            data_size   = 2'($urandom_range(0, 2));
            data_addr   = $urandom;
            data_wstrb  = 4'($urandom);
            data_wdata  = $urandom;
            mem_addr_ok = ($urandom_range(0, 99) < 50);
            mem_data_ok = ($urandom_range(0, 99) < 40);
            mem_rdata   = $urandom;
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
